// File: rtl/mw_sweep_sequencer.sv
// Controller-side MW frequency sweep sequencer driving the POP MW_invalid / laser_tuning / ADC_sample handshake.
// Optional watchdog in ACQUIRE enabled by defining SWEEP_TIMEOUT_EN (default build: timeout tied to 0).
module mw_sweep_sequencer #(
    parameter int SAMPLES_PER_STEP = 16,
    parameter int SETTLE_CYCLES    = 250,
    parameter int NUM_STEPS        = 64,
    parameter int STEP_W           = 8,
    parameter int CNT_W            = 16,
    parameter int TIMEOUT_CYCLES   = 50000
) (
    input  logic              clk_2M5,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              tune_req,
    input  logic              adc_sample,
    output logic              mw_invalid,
    output logic              laser_tuning,
    output logic              step_strobe,
    output logic [STEP_W-1:0] step_index,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    typedef enum logic [1:0] {IDLE, TUNE, RETUNE, ACQUIRE} state_t;

    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLES_PER_STEP - 1);
    localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(NUM_STEPS - 1);

    state_t              state_q, state_d;
    logic                adc_q;
    logic [CNT_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                mw_q, mw_d;
    logic                lt_q, lt_d;
    logic                strobe_q, strobe_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                adc_edge;

`ifdef SWEEP_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]    wdog_cnt_q, wdog_cnt_d;
    logic                timeout_q, timeout_d;
`endif

    assign adc_edge = adc_sample & ~adc_q;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        sample_cnt_d = sample_cnt_q;
        step_d       = step_q;
        mw_d         = mw_q;
        lt_d         = lt_q;
        strobe_d     = 1'b0;
        valid_d      = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
`ifdef SWEEP_TIMEOUT_EN
        wdog_cnt_d   = wdog_cnt_q;
        timeout_d    = timeout_q;
`endif

        case (state_q)
            IDLE: begin
                if (tune_req) begin
                    state_d = TUNE;
                    lt_d    = 1'b1;
                end else if (start) begin
                    state_d      = RETUNE;
                    step_d       = '0;
                    done_d       = 1'b0;
                    strobe_d     = 1'b1;
                    mw_d         = 1'b1;
                    busy_d       = 1'b1;
                    settle_cnt_d = SETTLE_LOAD;
                    sample_cnt_d = '0;
`ifdef SWEEP_TIMEOUT_EN
                    timeout_d    = 1'b0;
`endif
                end
            end
            TUNE: begin
                if (!tune_req) begin
                    state_d = IDLE;
                    lt_d    = 1'b0;
                end
            end
            RETUNE: begin
                if (settle_cnt_q == '0) begin
                    state_d    = ACQUIRE;
                    mw_d       = 1'b0;
`ifdef SWEEP_TIMEOUT_EN
                    wdog_cnt_d = '0;
`endif
                end else begin
                    settle_cnt_d = settle_cnt_q - CNT_W'(1);
                end
            end
            ACQUIRE: begin
                if (adc_edge) begin
                    valid_d = 1'b1;
`ifdef SWEEP_TIMEOUT_EN
                    wdog_cnt_d = '0;
`endif
                    if (sample_cnt_q == SAMPLE_LAST) begin
                        sample_cnt_d = '0;
                        if (step_q == STEP_LAST) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d      = RETUNE;
                            step_d       = step_q + STEP_W'(1);
                            strobe_d     = 1'b1;
                            mw_d         = 1'b1;
                            settle_cnt_d = SETTLE_LOAD;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    end
                end
`ifdef SWEEP_TIMEOUT_EN
                else if (wdog_cnt_q == TIMEOUT_LAST) begin
                    // ADC triggers stopped arriving: give up on the sweep
                    state_d      = IDLE;
                    timeout_d    = 1'b1;
                    step_d       = '0;
                    done_d       = 1'b0;
                    busy_d       = 1'b0;
                    sample_cnt_d = '0;
                    wdog_cnt_d   = '0;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // abort overrides everything, including a same-cycle start or final edge
        if (abort) begin
            state_d      = IDLE;
            step_d       = '0;
            done_d       = 1'b0;
            mw_d         = 1'b0;
            lt_d         = 1'b0;
            busy_d       = 1'b0;
            strobe_d     = 1'b0;
            valid_d      = 1'b0;
            settle_cnt_d = '0;
            sample_cnt_d = '0;
`ifdef SWEEP_TIMEOUT_EN
            wdog_cnt_d   = '0;
            timeout_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_2M5 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            adc_q        <= 1'b0;
            settle_cnt_q <= '0;
            sample_cnt_q <= '0;
            step_q       <= '0;
            mw_q         <= 1'b0;
            lt_q         <= 1'b0;
            strobe_q     <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SWEEP_TIMEOUT_EN
            wdog_cnt_q   <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            adc_q        <= adc_sample;
            settle_cnt_q <= settle_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            step_q       <= step_d;
            mw_q         <= mw_d;
            lt_q         <= lt_d;
            strobe_q     <= strobe_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SWEEP_TIMEOUT_EN
            wdog_cnt_q   <= wdog_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign mw_invalid   = mw_q;
    assign laser_tuning = lt_q;
    assign step_strobe  = strobe_q;
    assign step_index   = step_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
`ifdef SWEEP_TIMEOUT_EN
    assign timeout      = timeout_q;
`else
    assign timeout      = 1'b0;
`endif

endmodule

// File: doc/mw_sweep_sequencer.md
Name: mw_sweep_sequencer

Overview:
- Drives the MW_invalid / laser_tuning / ADC_sample handshake of the POP timing core from the controller side.
- Steps an external MW synthesizer through NUM_STEPS frequency points.
- At each point it holds mw_invalid high while the synthesizer settles, then counts SAMPLES_PER_STEP ADC_sample triggers before moving to the next point.
- Sits beside the POP timers on clk_2M5: adc_sample is fed from the POP block's ADC_sample output, and mw_invalid / laser_tuning feed the POP block's MW_invalid / laser_tuning inputs.

Parameters:
- SAMPLES_PER_STEP, 16: ADC trigger rising edges acquired per frequency step; must be ≥1.
- SETTLE_CYCLES, 250: clk_2M5 cycles mw_invalid is held high per retune (100 µs); must be ≥1.
- NUM_STEPS, 64: frequency points per sweep; must be ≥1 and ≤2^STEP_W.
- STEP_W, 8: width of step_index.
- CNT_W, 16: width of the internal settle, sample and timeout counters.
- TIMEOUT_CYCLES, 50000: watchdog limit; used only with SWEEP_TIMEOUT_EN.

Ports:
- clk_2M5  in  1  2.5 MHz system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle sweep request.
- abort  in  1  one-cycle sweep cancel.
- tune_req  in  1  level; laser frequency setup request.
- adc_sample  in  1  ADC trigger from POP timers, synchronous to clk_2M5.
- mw_invalid  out  1  high = suppress POP/ADC activity during retune.
- laser_tuning  out  1  high = POP block in laser setup.
- step_strobe  out  1  one-cycle pulse commanding synthesizer to the step_index frequency.
- step_index  out  STEP_W  current frequency point.
- sample_valid  out  1  one-cycle pulse per counted ADC trigger.
- busy  out  1  high in RETUNE/ACQUIRE.
- done  out  1  sweep completed; held until next start or abort.
- timeout  out  1  sticky watchdog flag; tied 0 when feature disabled.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, registered adc_sample copy (adc_d) 0.
- All outputs are registered.
- Edge detect: edge = adc_sample & !adc_d; adc_d is updated every cycle in every state.
- States: IDLE, TUNE, RETUNE, ACQUIRE.
- IDLE:
  - start & !tune_req → RETUNE next cycle: step_index=0, done=0, timeout=0.
  - tune_req → TUNE.
  - If start and tune_req are both high in the same cycle, tune_req wins.
- TUNE:
  - laser_tuning=1 starting the cycle after tune_req is seen.
  - start is ignored.
  - Leaves for IDLE the cycle after tune_req falls; laser_tuning=0 on that same cycle.
- RETUNE:
  - On entry: step_strobe=1 for exactly one cycle, mw_invalid=1, busy=1, settle counter loaded with SETTLE_CYCLES-1.
  - Counter decrements each cycle; at 0 → ACQUIRE.
  - mw_invalid is high for exactly SETTLE_CYCLES consecutive cycles per step.
  - Edges are ignored.
- ACQUIRE:
  - mw_invalid=0.
  - Each edge seen while the state register is ACQUIRE increments the sample count; sample_valid pulses the cycle after the edge.
  - If adc_sample is already high on entry, that edge is not counted.
  - On the SAMPLES_PER_STEP-th edge: sample count clears.
    - If step_index == NUM_STEPS-1: → IDLE, done=1, busy=0.
    - Otherwise: step_index+1, → RETUNE (new step_strobe).
- start while busy: ignored.
- tune_req while busy: ignored. It is serviced from IDLE once the sweep ends, if still asserted.
- abort in any state:
  - Next cycle: IDLE; step_index=0; done=0; mw_invalid=0; laser_tuning=0; busy=0.
  - A pending sample_valid is dropped.
  - abort beats start when both arrive in the same cycle.
- step_index never wraps: the sweep ends at NUM_STEPS-1.

Optional Feature:
- Macro: SWEEP_TIMEOUT_EN.
- Defined:
  - Watchdog counter runs in ACQUIRE; it clears on every edge and on entry to ACQUIRE.
  - Reaching TIMEOUT_CYCLES with no edge → IDLE next cycle, timeout=1 (sticky until start/abort), step_index=0, done=0.
  - Covers the case where the POP block is held off and ADC_sample stops arriving.
- Undefined:
  - No watchdog logic; timeout is tied to 0.
  - ACQUIRE waits indefinitely for edges.

Test Plan (SAMPLES_PER_STEP=2, SETTLE_CYCLES=4, NUM_STEPS=3, TIMEOUT_CYCLES=20):
- Reset asserted mid-RETUNE with adc_sample toggling → all outputs 0 immediately; they stay 0 after release with no start.
- start pulse, adc_sample pulses every 10 cycles → exactly 3 step_strobes with step_index 0,1,2; mw_invalid high exactly 4 cycles after each strobe; 6 sample_valid pulses; then done=1, busy=0, step_index=2.
- adc_sample edges only during mw_invalid high → no sample_valid; state stays ACQUIRE after settle until post-settle edges arrive.
- abort on the cycle after the second step_strobe → next cycle busy=0, mw_invalid=0, step_index=0, done=0; a later start restarts from step 0.
- tune_req high in IDLE with start pulsed in the same cycle → laser_tuning=1 next cycle, no step_strobe; tune_req low → laser_tuning=0 next cycle.
- SWEEP_TIMEOUT_EN defined, no adc_sample edges after settle → 20 cycles into ACQUIRE: timeout=1, busy=0. Undefined: busy stays 1, timeout stays 0.
